jam_perm_gen: RTL and testbench
===============================

# jam_perm_gen

Permutation generator that sits directly upstream of the JAM cost-accumulation datapath. After `start`, it enumerates all N! worker-to-job assignments in lexicographic order, beginning with the identity and ending with the full reversal. Each permutation is presented over a valid/ready handshake. Alongside each permutation it reports the lowest worker index whose job changed, so the downstream accumulator can reuse partial sums. It signals `done` after the final permutation has been accepted.

## Interface
- `N`, default 8: number of workers, which equals the number of jobs.
- `IW`, default 3: index width, equal to $clog2(N).
- `CLK`  in  1  clock.
- `RST`  in  1  reset; synchronous, active-high.
- `start`  in  1  begin enumeration. Sampled only in IDLE.
- `perm`  out  N*IW  job for worker w at `perm[w*IW +: IW]`. Worker 0 is the most significant position for ordering.
- `chg_idx`  out  IW  lowest worker index whose job differs from the previous permutation. It is 0 for the first permutation.
- `perm_valid`  out  1  `perm`, `chg_idx` and `last` are valid.
- `perm_ready`  in  1  consumer accepts the permutation.
- `last`  out  1  current permutation is the final one (N-1 … 0).
- `done`  out  1  one-cycle pulse after the final permutation is accepted.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States and transitions:
  - IDLE: on `start`, load the identity (job w → worker w), set `chg_idx`=0, go to OUT.
  - OUT: `perm_valid`=1. On handshake (`perm_valid & perm_ready`):
    - if `last`, go to FIN;
    - otherwise go to CALC.
  - CALC: combinationally find the pivot i, the largest i in 0..N-2 with p[i] < p[i+1]. Then find the successor j, the largest j > i with p[j] > p[i]. Register p with p[i] and p[j] swapped, and register `chg_idx`=i. Go to REV.
  - REV: reverse p[i+1..N-1] in parallel, in one cycle. Go to OUT.
  - FIN: `done`=1 for one cycle, go to IDLE.
- `last` is combinational on the current p: it is asserted when no pivot exists, i.e. p is strictly decreasing. It is valid only while `perm_valid`=1.
- While `perm_valid`=1 and `perm_ready`=0, `perm`, `chg_idx` and `last` are held stable.
- `start` is ignored outside IDLE.
- In IDLE, `perm` holds its last value; this value is don't-care to consumers.
- Job values stay within 0..N-1 at all times. Every permutation appears exactly once; the total is N! = 40320 for N=8.

## Timing
- Reset values, applied at the first edge with RST=1:
  - state = IDLE;
  - `perm` = 0;
  - `chg_idx` = 0;
  - `perm_valid`, `last`, `done`, `busy` = 0.
- `start` sampled at edge k: `perm_valid`=1 after edge k+1.
- Handshake at edge k: `perm_valid`=0 after k+1 (CALC) and k+2 (REV), then 1 after k+3.
- Throughput: one permutation per 3 cycles when `perm_ready` is held high. Full N=8 run: the final `perm_valid` rises 1 + 3·40319 cycles after `start`.
- Final handshake at edge k: `done`=1 after k+1 only; `busy`=0 after k+2.
- RST mid-operation: all outputs return to reset values after that edge. A later `start` restarts from the identity.
- RST coinciding with `start` or a handshake: RST wins.

## Structure
- Shared package `jam_pkg` holds:
  - constants `N_WORKERS`=8 and `IDX_W`=3;
  - `typedef logic [IDX_W-1:0] idx_t`;
  - `typedef idx_t perm_t [N_WORKERS]`;
  - the state enum {IDLE, OUT, CALC, REV, FIN}.
- One combinational sub-module, `jam_next_perm`, takes p and returns the pivot, the successor, a has-pivot flag and the swapped array. The top level holds the FSM, registers and reversal.

## Test plan
- Identity start: reset, pulse `start` with `perm_ready`=1 → after 1 cycle `perm`=0,1,2,3,4,5,6,7, `chg_idx`=0, `last`=0.
- Sequence order: continue with `perm_ready`=1 → the 2nd permutation is 0,1,2,3,4,5,7,6 with `chg_idx`=6, and the 3rd is 0,1,2,3,4,6,5,7 with `chg_idx`=5. Each arrives exactly 3 cycles after the previous handshake.
- Backpressure: hold `perm_ready`=0 for 10 cycles on the 3rd permutation → `perm`, `chg_idx` and `perm_valid` are unchanged. Raise `perm_ready` → the 4th permutation, 0,1,2,3,4,6,7,5, arrives 3 cycles later.
- Full run: count handshakes → exactly 40320, all distinct, each lexicographically greater than the previous. `last`=1 only on 7,6,5,4,3,2,1,0. `done` pulses once, 1 cycle after the final handshake; `busy`=0 one cycle after that.
- Reset mid-run: assert RST during the 100th permutation → reset values after that edge. A new `start` yields the identity again.
- Spurious start: pulse `start` during CALC/OUT → no effect on the sequence or its cycle counts.

Source files
------------

// File: rtl/jam_pkg.sv
// Shared types and constants for the JAM permutation front end.
package jam_pkg;

  localparam int unsigned N_WORKERS = 8;
  localparam int unsigned IDX_W     = 3;

  typedef logic [IDX_W-1:0] idx_t;
  typedef idx_t perm_t [N_WORKERS];

  typedef enum logic [2:0] {
    IDLE,
    OUT,
    CALC,
    REV,
    FIN
  } state_e;

endpackage

// File: rtl/jam_next_perm.sv
// Combinational pivot/successor search and swap for the next lexicographic permutation.
module jam_next_perm
  import jam_pkg::*;
#(
  parameter int unsigned N  = N_WORKERS,
  parameter int unsigned IW = IDX_W
) (
  input  logic [IW-1:0] p       [N],
  output logic [IW-1:0] pivot,
  output logic [IW-1:0] succ,
  output logic          has_pivot,
  output logic [IW-1:0] swapped [N]
);

  always_comb begin
    pivot     = '0;
    has_pivot = 1'b0;
    // Ascending scan so the last hit is the largest qualifying index.
    for (int i = 0; i < int'(N) - 1; i++) begin
      if (p[i] < p[i+1]) begin
        pivot     = IW'(i);
        has_pivot = 1'b1;
      end
    end

    succ = '0;
    for (int j = 0; j < int'(N); j++) begin
      if (j > int'(pivot) && p[j] > p[pivot]) begin
        succ = IW'(j);
      end
    end

    swapped = p;
    if (has_pivot) begin
      swapped[pivot] = p[succ];
      swapped[succ]  = p[pivot];
    end
  end

endmodule

// File: rtl/jam_perm_gen.sv
// Enumerates all N! worker-to-job assignments in lexicographic order over valid/ready,
// reporting the lowest changed worker index alongside each one.
module jam_perm_gen
  import jam_pkg::*;
#(
  parameter int unsigned N  = N_WORKERS,
  parameter int unsigned IW = IDX_W
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  output logic [N*IW-1:0] perm,
  output logic [IW-1:0] chg_idx,
  output logic          perm_valid,
  input  logic          perm_ready,
  output logic          last,
  output logic          done,
  output logic          busy
);

  state_e        state_q, state_d;
  logic [IW-1:0] p_q [N];
  logic [IW-1:0] p_d [N];
  logic [IW-1:0] chg_q, chg_d;

  logic [IW-1:0] nx_pivot;
  logic [IW-1:0] nx_succ;
  logic          nx_has_pivot;
  logic [IW-1:0] nx_swapped [N];

  jam_next_perm #(
    .N  (N),
    .IW (IW)
  ) u_next (
    .p         (p_q),
    .pivot     (nx_pivot),
    .succ      (nx_succ),
    .has_pivot (nx_has_pivot),
    .swapped   (nx_swapped)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      chg_q   <= '0;
      for (int w = 0; w < int'(N); w++) begin
        p_q[w] <= '0;
      end
    end else begin
      state_q <= state_d;
      chg_q   <= chg_d;
      p_q     <= p_d;
    end
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    chg_d   = chg_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          for (int w = 0; w < int'(N); w++) begin
            p_d[w] = IW'(w);
          end
          chg_d   = '0;
          state_d = OUT;
        end
      end
      OUT: begin
        if (perm_ready) begin
          state_d = nx_has_pivot ? CALC : FIN;
        end
      end
      CALC: begin
        p_d     = nx_swapped;
        chg_d   = nx_pivot;
        state_d = REV;
      end
      REV: begin
        // chg_q holds the pivot; the suffix after it is strictly decreasing, so flip it.
        for (int k = 0; k < int'(N); k++) begin
          if (k > int'(chg_q)) begin
            p_d[k] = p_q[IW'(int'(N) + int'(chg_q) - k)];
          end
        end
        state_d = OUT;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    perm = '0;
    for (int w = 0; w < int'(N); w++) begin
      perm[w*IW +: IW] = p_q[w];
    end
    chg_idx    = chg_q;
    perm_valid = (state_q == OUT);
    last       = perm_valid & ~nx_has_pivot;
    done       = (state_q == FIN);
    busy       = (state_q != IDLE);
  end

  // CALC is only entered from a non-final permutation, so a successor always exists.
  a_calc_has_succ: assert property (@(posedge CLK) disable iff (RST)
    (state_q == CALC) |-> (nx_has_pivot && (nx_succ > nx_pivot)));

endmodule

// File: tb/tb_jam_perm_gen.sv
// Self-checking bench: N=8 instance for ordering/backpressure/reset, N=5 instance for full runs.
module tb_jam_perm_gen;

  localparam int NA  = 8;
  localparam int NB  = 5;
  localparam int IWX = 3;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic                rst_a = 1'b1, start_a = 1'b0, ready_a = 1'b0;
  logic [NA*IWX-1:0]   perm_a;
  logic [IWX-1:0]      chg_a;
  logic                valid_a, last_a, done_a, busy_a;

  logic                rst_b = 1'b1, start_b = 1'b0, ready_b = 1'b0;
  logic [NB*IWX-1:0]   perm_b;
  logic [IWX-1:0]      chg_b;
  logic                valid_b, last_b, done_b, busy_b;

  int n_cmp = 0;
  int n_bad = 0;
  bit seen [logic [NB*IWX-1:0]];

  jam_perm_gen #(.N(NA), .IW(IWX)) dut_a (
    .CLK(CLK), .RST(rst_a), .start(start_a), .perm(perm_a), .chg_idx(chg_a),
    .perm_valid(valid_a), .perm_ready(ready_a), .last(last_a), .done(done_a), .busy(busy_a)
  );

  jam_perm_gen #(.N(NB), .IW(IWX)) dut_b (
    .CLK(CLK), .RST(rst_b), .start(start_b), .perm(perm_b), .chg_idx(chg_b),
    .perm_valid(valid_b), .perm_ready(ready_b), .last(last_b), .done(done_b), .busy(busy_b)
  );

  function automatic int fact(input int n);
    int f = 1;
    for (int i = 2; i <= n; i++) f *= i;
    return f;
  endfunction

  // r-th permutation of 0..n-1 in lexicographic order via the factorial number system.
  function automatic void unrank(input int n, input int r, output int res [8]);
    int avail[$];
    int rem = r;
    int f, d;
    for (int i = 0; i < 8; i++) res[i] = 0;
    for (int i = 0; i < n; i++) avail.push_back(i);
    for (int pos = 0; pos < n; pos++) begin
      f = fact(n - 1 - pos);
      d = rem / f;
      rem = rem % f;
      res[pos] = avail[d];
      avail.delete(d);
    end
  endfunction

  function automatic logic [23:0] exp_perm(input int n, input int r);
    int a [8];
    logic [23:0] v = '0;
    unrank(n, r, a);
    for (int w = 0; w < n; w++) v[w*3 +: 3] = a[w][2:0];
    return v;
  endfunction

  function automatic int exp_chg(input int n, input int r);
    int a [8];
    int b [8];
    if (r == 0) return 0;
    unrank(n, r, a);
    unrank(n, r - 1, b);
    for (int w = 0; w < n; w++) if (a[w] != b[w]) return w;
    return 0;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_valid_a(output int e);
    e = 0;
    do begin
      tick();
      e++;
    end while (!valid_a && e < 20);
  endtask

  task automatic test_reset();
    rst_a = 1'b1; start_a = 1'b1; ready_a = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({perm_a, chg_a, valid_a, last_a, done_a, busy_a} !== '0) begin
      n_bad++;
      $display("FAIL reset_a: got %h want 0", {perm_a, chg_a, valid_a, last_a, done_a, busy_a});
    end
    rst_a = 1'b0; start_a = 1'b0;
    tick();
    n_cmp++;
    if ({valid_a, busy_a} !== 2'b00) begin
      n_bad++;
      $display("FAIL idle_a: valid/busy got %b want 00", {valid_a, busy_a});
    end
  endtask

  task automatic test_identity();
    start_a = 1'b1; ready_a = 1'b1;
    tick();
    start_a = 1'b0;
    n_cmp++;
    if ({valid_a, busy_a, last_a, chg_a} !== {3'b110, 3'd0} || perm_a !== exp_perm(NA, 0)) begin
      n_bad++;
      $display("FAIL identity: v/b/l/chg=%b/%b/%b/%0d perm=%h want 1/1/0/0 %h",
               valid_a, busy_a, last_a, chg_a, perm_a, exp_perm(NA, 0));
    end
  endtask

  task automatic test_order();
    int e;
    for (int r = 1; r <= 2; r++) begin
      wait_valid_a(e);
      n_cmp++;
      if (e !== 3) begin n_bad++; $display("FAIL order_lat r=%0d: got %0d want 3", r, e); end
      n_cmp++;
      if (perm_a !== exp_perm(NA, r) || chg_a !== 3'(exp_chg(NA, r))) begin
        n_bad++;
        $display("FAIL order r=%0d: perm=%h chg=%0d want %h %0d", r, perm_a, chg_a,
                 exp_perm(NA, r), exp_chg(NA, r));
      end
    end
  endtask

  task automatic test_backpressure();
    int e;
    ready_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (valid_a !== 1'b1 || perm_a !== exp_perm(NA, 2) || chg_a !== 3'(exp_chg(NA, 2))) begin
        n_bad++;
        $display("FAIL hold i=%0d: v=%b perm=%h chg=%0d want 1 %h %0d", i, valid_a, perm_a,
                 chg_a, exp_perm(NA, 2), exp_chg(NA, 2));
      end
    end
    ready_a = 1'b1;
    wait_valid_a(e);
    n_cmp++;
    if (e !== 3 || perm_a !== exp_perm(NA, 3)) begin
      n_bad++;
      $display("FAIL release: lat=%0d perm=%h want 3 %h", e, perm_a, exp_perm(NA, 3));
    end
  endtask

  // Random ready and spurious starts; RST lands on the 100th permutation.
  task automatic test_random_reset();
    int  r = 3, cd = 0, it = 0;
    bit  exp_valid = 1'b1, hs;
    while (!(r == 99 && exp_valid) && it < 2000) begin
      hs = exp_valid && ready_a;
      tick();
      it++;
      ready_a = ($urandom_range(0, 3) != 0);
      start_a = ($urandom_range(0, 4) == 0);
      if (hs) begin r++; cd = 2; exp_valid = 1'b0; end
      else if (cd > 0) begin cd--; exp_valid = (cd == 0); end
      n_cmp++;
      if (valid_a !== exp_valid) begin
        n_bad++;
        $display("FAIL rnd_valid r=%0d: got %b want %b", r, valid_a, exp_valid);
      end
      if (exp_valid) begin
        n_cmp++;
        if (perm_a !== exp_perm(NA, r) || chg_a !== 3'(exp_chg(NA, r)) ||
            last_a !== (r == fact(NA) - 1)) begin
          n_bad++;
          $display("FAIL rnd r=%0d: perm=%h chg=%0d last=%b want %h %0d", r, perm_a, chg_a,
                   last_a, exp_perm(NA, r), exp_chg(NA, r));
        end
      end
    end
    n_cmp++;
    if (r !== 99) begin n_bad++; $display("FAIL rnd_progress: got r=%0d want 99", r); end
    rst_a = 1'b1; ready_a = 1'b1; start_a = 1'b1;
    tick();
    n_cmp++;
    if ({perm_a, chg_a, valid_a, last_a, done_a, busy_a} !== '0) begin
      n_bad++;
      $display("FAIL midrun_reset: got %h want 0", {perm_a, chg_a, valid_a, last_a, done_a, busy_a});
    end
    rst_a = 1'b0;
    tick();
    start_a = 1'b0;
    n_cmp++;
    if (valid_a !== 1'b1 || perm_a !== exp_perm(NA, 0) || chg_a !== 3'd0) begin
      n_bad++;
      $display("FAIL restart: v=%b perm=%h chg=%0d want 1 %h 0", valid_a, perm_a, chg_a,
               exp_perm(NA, 0));
    end
  endtask

  task automatic run_full_b(input bit rnd);
    int  r = 0, cd = 1, edges = 0, total = fact(NB);
    bit  exp_valid = 1'b0, hs, finished = 1'b0;
    logic [23:0] ep;
    logic [NB*IWX-1:0] epb;
    seen.delete();
    rst_b = 1'b1;
    tick();
    n_cmp++;
    if ({perm_b, chg_b, valid_b, last_b, done_b, busy_b} !== '0) begin
      n_bad++;
      $display("FAIL reset_b: got %h want 0", {perm_b, chg_b, valid_b, last_b, done_b, busy_b});
    end
    rst_b = 1'b0; ready_b = 1'b1; start_b = 1'b1;
    while (!finished && edges < 3000) begin
      hs = exp_valid && ready_b;
      if (hs) begin
        n_cmp++;
        if (seen.exists(perm_b)) begin n_bad++; $display("FAIL dup: perm=%h", perm_b); end
        seen[perm_b] = 1'b1;
      end
      tick();
      edges++;
      start_b = rnd ? ($urandom_range(0, 5) == 0) : 1'b0;
      if (hs && r == total - 1) begin
        start_b = 1'b0;
        n_cmp++;
        if (done_b !== 1'b1) begin n_bad++; $display("FAIL done_pulse: got %b want 1", done_b); end
        tick();
        n_cmp++;
        if ({done_b, busy_b, valid_b} !== 3'b000) begin
          n_bad++;
          $display("FAIL post_done: done/busy/valid=%b want 000", {done_b, busy_b, valid_b});
        end
        finished = 1'b1;
      end else begin
        if (hs) begin r++; cd = 2; exp_valid = 1'b0; end
        else if (cd > 0) begin
          cd--;
          exp_valid = (cd == 0);
          if (exp_valid && r == total - 1 && !rnd) begin
            n_cmp++;
            if (edges !== 1 + 3 * (total - 1)) begin
              n_bad++;
              $display("FAIL final_rise: got %0d want %0d", edges, 1 + 3 * (total - 1));
            end
          end
        end
        n_cmp++;
        if (valid_b !== exp_valid || done_b !== 1'b0) begin
          n_bad++;
          $display("FAIL b_valid r=%0d: valid=%b done=%b want %b 0", r, valid_b, done_b, exp_valid);
        end
        if (exp_valid) begin
          ep  = exp_perm(NB, r);
          epb = ep[NB*IWX-1:0];
          n_cmp++;
          if (perm_b !== epb || chg_b !== 3'(exp_chg(NB, r)) || last_b !== (r == total - 1)) begin
            n_bad++;
            $display("FAIL b_perm r=%0d: perm=%h chg=%0d last=%b want %h %0d %b", r, perm_b,
                     chg_b, last_b, epb, exp_chg(NB, r), r == total - 1);
          end
        end
        ready_b = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
    end
    n_cmp++;
    if (!finished || seen.num() != total) begin
      n_bad++;
      $display("FAIL b_count: finished=%b distinct=%0d want 1 %0d", finished, seen.num(), total);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_identity();
    test_order();
    test_backpressure();
    test_random_reset();
    run_full_b(1'b0);
    run_full_b(1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
